// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Purpose  : Generic pipeline-boundary register with valid/ready handshake,
//            optional 2-entry skid buffer, bubble insertion and flush.
// Revision : 1.0
// ============================================================================
module pipe_stage_buf #(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 48,
    parameter bit                SKID        = 1'b1,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_bubble,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              r_head_valid;
    logic [DATA_W-1:0] r_head_data;
    logic [CTRL_W-1:0] r_head_ctrl;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_accept;
    logic              w_pop;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_in_ctrl;

    assign w_accept  = in_valid & in_ready;
    assign w_pop     = r_head_valid & out_ready;
    assign w_in_ctrl = in_bubble ? BUBBLE_CTRL : in_ctrl;

    assign out_valid  = r_head_valid;
    assign out_data   = r_head_data;
    // Invalid head must never leak write-enables downstream.
    assign out_ctrl   = r_head_valid ? r_head_ctrl : '0;
    assign occupancy  = {1'b0, r_head_valid} + {1'b0, w_skid_valid};
    assign bubble_cnt = r_bubble_cnt;

    always_ff @(negedge cpu_clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (w_accept && in_bubble && !flush && !(&r_bubble_cnt)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    generate
        if (SKID) begin : g_skid
            logic              r_skid_valid;
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic              r_in_ready;

            assign in_ready     = r_in_ready;
            assign w_skid_valid = r_skid_valid;

            always_ff @(negedge cpu_clk or posedge reset) begin
                if (reset) begin
                    r_head_valid <= 1'b0;
                    r_head_data  <= '0;
                    r_head_ctrl  <= '0;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                    r_skid_ctrl  <= '0;
                    r_in_ready   <= 1'b0;
                end else if (flush) begin
                    r_head_valid <= 1'b0;
                    r_head_data  <= '0;
                    r_head_ctrl  <= '0;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                    r_skid_ctrl  <= '0;
                    r_in_ready   <= 1'b1;
                end else begin
                    r_in_ready <= 1'b1;
                    if (r_skid_valid) begin
                        // in_ready is low here, so no accept can coincide.
                        if (w_pop) begin
                            r_head_data  <= r_skid_data;
                            r_head_ctrl  <= r_skid_ctrl;
                            r_skid_valid <= 1'b0;
                        end else begin
                            r_in_ready <= 1'b0;
                        end
                    end else if (r_head_valid && !w_pop) begin
                        if (w_accept) begin
                            r_skid_valid <= 1'b1;
                            r_skid_data  <= in_data;
                            r_skid_ctrl  <= w_in_ctrl;
                            r_in_ready   <= 1'b0;
                        end
                    end else begin
                        r_head_valid <= w_accept;
                        if (w_accept) begin
                            r_head_data <= in_data;
                            r_head_ctrl <= w_in_ctrl;
                        end
                    end
                end
            end
        end else begin : g_single
            logic r_rdy_en;

            assign in_ready     = r_rdy_en & (~r_head_valid | out_ready);
            assign w_skid_valid = 1'b0;

            always_ff @(negedge cpu_clk or posedge reset) begin
                if (reset) begin
                    r_head_valid <= 1'b0;
                    r_head_data  <= '0;
                    r_head_ctrl  <= '0;
                    r_rdy_en     <= 1'b0;
                end else begin
                    r_rdy_en <= 1'b1;
                    if (flush) begin
                        r_head_valid <= 1'b0;
                        r_head_data  <= '0;
                        r_head_ctrl  <= '0;
                    end else if (w_accept) begin
                        r_head_valid <= 1'b1;
                        r_head_data  <= in_data;
                        r_head_ctrl  <= w_in_ctrl;
                    end else if (w_pop) begin
                        r_head_valid <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Purpose  : Checks a skid instance and a single-entry instance against a
//            queue-based model of the stage.
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_buf;

    logic        cpu_clk;
    logic        reset;
    logic        flush;

    logic        a_in_valid, a_in_ready, a_in_bubble, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [7:0]  a_in_ctrl, a_out_ctrl;
    logic [1:0]  a_occupancy;
    logic [1:0]  a_bubble_cnt;

    logic        b_in_valid, b_in_ready, b_in_bubble, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [1:0]  b_occupancy;
    logic [3:0]  b_bubble_cnt;

    pipe_stage_buf #(
        .DATA_W(32), .CTRL_W(8), .SKID(1'b1), .BUBBLE_CTRL(8'h00), .CNT_W(2)
    ) u_a (
        .cpu_clk(cpu_clk), .reset(reset), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bubble(a_in_bubble),
        .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .occupancy(a_occupancy), .bubble_cnt(a_bubble_cnt)
    );

    pipe_stage_buf #(
        .DATA_W(32), .CTRL_W(8), .SKID(1'b0), .BUBBLE_CTRL(8'h5A), .CNT_W(4)
    ) u_b (
        .cpu_clk(cpu_clk), .reset(reset), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bubble(b_in_bubble),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .occupancy(b_occupancy), .bubble_cnt(b_bubble_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Reference model: each stage is a bounded FIFO of {data, ctrl}.
    logic [39:0] qa[$];
    logic [39:0] qb[$];
    logic        ma_rdy;
    logic        mb_en;
    int          ma_cnt;
    int          mb_cnt;
    int          n_assert;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post_check();
        chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
        if (qa.size() != 0) begin
            chk("a_out_data", 64'(a_out_data), 64'(qa[0][39:8]));
            chk("a_out_ctrl", 64'(a_out_ctrl), 64'(qa[0][7:0]));
        end else begin
            chk("a_out_ctrl_idle", 64'(a_out_ctrl), 64'(0));
        end
        chk("a_occupancy", 64'(a_occupancy), 64'(qa.size()));
        chk("a_bubble_cnt", 64'(a_bubble_cnt), 64'(ma_cnt));
        chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
        if (qb.size() != 0) begin
            chk("b_out_data", 64'(b_out_data), 64'(qb[0][39:8]));
            chk("b_out_ctrl", 64'(b_out_ctrl), 64'(qb[0][7:0]));
        end else begin
            chk("b_out_ctrl_idle", 64'(b_out_ctrl), 64'(0));
        end
        chk("b_occupancy", 64'(b_occupancy), 64'(qb.size()));
        chk("b_bubble_cnt", 64'(b_bubble_cnt), 64'(mb_cnt));
    endtask

    // One falling edge: check in_ready before it, update model, check outputs after.
    task automatic step();
        logic a_acc, a_pop, b_acc, b_pop, b_rdy;
        #1;
        b_rdy = mb_en && (qb.size() == 0 || b_out_ready);
        chk("a_in_ready", 64'(a_in_ready), 64'(ma_rdy));
        chk("b_in_ready", 64'(b_in_ready), 64'(b_rdy));
        a_acc = a_in_valid && ma_rdy;
        a_pop = (qa.size() != 0) && a_out_ready;
        b_acc = b_in_valid && b_rdy;
        b_pop = (qb.size() != 0) && b_out_ready;
        @(negedge cpu_clk);
        if (!reset) begin
            if (flush) begin
                qa.delete();
            end else begin
                if (a_pop) void'(qa.pop_front());
                if (a_acc) begin
                    qa.push_back({a_in_data, a_in_bubble ? 8'h00 : a_in_ctrl});
                    if (a_in_bubble && ma_cnt < 3) ma_cnt++;
                end
            end
            ma_rdy = (qa.size() < 2);
            if (b_pop) void'(qb.pop_front());
            if (b_acc) begin
                qb.push_back({b_in_data, b_in_bubble ? 8'h5A : b_in_ctrl});
                if (b_in_bubble && mb_cnt < 15) mb_cnt++;
            end
            mb_en = 1'b1;
        end
        #1;
        post_check();
    endtask

    initial begin
        logic [31:0] nxt;
        logic        acc;
        n_assert = 0; n_fail = 0;
        ma_rdy = 1'b0; mb_en = 1'b0; ma_cnt = 0; mb_cnt = 0;
        reset = 1'b1; flush = 1'b0;
        a_in_valid = 0; a_in_bubble = 0; a_in_data = 0; a_in_ctrl = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_bubble = 0; b_in_data = 0; b_in_ctrl = 0; b_out_ready = 0;

        // Reset held, then released
        step(); step();
        reset = 1'b0;
        step(); step();

        // Single pass through the skid instance
        a_in_data = 32'h1234; a_in_ctrl = 8'h03; a_in_valid = 1; a_out_ready = 1;
        step();
        a_in_valid = 0;
        step(); step();

        // Backpressure fills head and skid
        a_out_ready = 0; a_in_valid = 1;
        a_in_data = 32'h10; a_in_ctrl = 8'h01; step();
        a_in_data = 32'h20; a_in_ctrl = 8'h02; step();
        a_in_data = 32'hDEAD; step();
        a_in_valid = 0; a_out_ready = 1;
        step(); step(); step();

        // Bubble insertion and counter saturation
        a_in_valid = 1; a_in_bubble = 1; a_in_data = 32'hAA; a_in_ctrl = 8'hFF;
        step();
        a_in_valid = 0; a_in_bubble = 0;
        step();
        a_in_valid = 1; a_in_bubble = 1;
        for (int i = 0; i < 5; i++) begin
            a_in_data = 32'hB0 + 32'(i);
            step();
        end
        a_in_valid = 0; a_in_bubble = 0;
        step(); step();

        // Flush with two held entries and a simultaneous push
        a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 8'h11;
        a_in_data = 32'h40; step();
        a_in_data = 32'h50; step();
        a_in_data = 32'h30; a_in_bubble = 1; flush = 1; step();
        flush = 0; a_in_valid = 0; a_in_bubble = 0; a_out_ready = 1;
        step(); step();

        // Asynchronous reset between edges
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h77; a_in_ctrl = 8'hC3;
        step();
        a_in_valid = 0;
        #2; reset = 1'b1; #1;
        chk("a_async_valid", 64'(a_out_valid), 64'(0));
        chk("a_async_ctrl", 64'(a_out_ctrl), 64'(0));
        chk("a_async_data", 64'(a_out_data), 64'(0));
        chk("a_async_occ", 64'(a_occupancy), 64'(0));
        chk("a_async_bcnt", 64'(a_bubble_cnt), 64'(0));
        chk("a_async_rdy", 64'(a_in_ready), 64'(0));
        qa.delete(); qb.delete();
        ma_rdy = 1'b0; mb_en = 1'b0; ma_cnt = 0; mb_cnt = 0;
        step();
        reset = 1'b0;
        step(); step();

        // Single-entry instance: 8 back-to-back entries
        b_out_ready = 1; b_in_valid = 1; b_in_ctrl = 8'h21;
        for (int i = 0; i < 8; i++) begin
            b_in_data = 32'(i);
            step();
        end
        b_in_valid = 0;
        step();

        // One-cycle out_ready drop: input held until accepted
        nxt = 32'h100; b_in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            b_out_ready = (i != 3);
            b_in_data = nxt;
            acc = mb_en && (qb.size() == 0 || b_out_ready);
            step();
            if (acc) nxt = nxt + 1;
        end
        b_in_valid = 0; b_out_ready = 1;
        step();

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_bubble = ($urandom_range(0, 3) == 0);
            a_in_data   = $urandom;
            a_in_ctrl   = 8'($urandom);
            a_out_ready = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_bubble = ($urandom_range(0, 3) == 0);
            b_in_data   = $urandom;
            b_in_ctrl   = 8'($urandom);
            b_out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        flush = 0; a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
        step(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
